// File: rtl/param_datapath.sv
// Register file of NREGS x WIDTH with a PC register, a single-cycle ALU and a
// shift-add multiplier sequenced by a two-state FSM (issue/busy/done handshake).
module param_datapath #(
  parameter int WIDTH  = 16,
  parameter int NREGS  = 16,
  parameter int PC_REG = 0,
  parameter int SELW   = $clog2(NREGS),
  parameter int SHW    = $clog2(WIDTH)
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   program_counter_increment,
  input  logic                   issue,
  input  logic [3:0]             alu_op,
  input  logic [SELW-1:0]        alu_a_select,
  input  logic [SELW-1:0]        alu_b_select,
  input  logic                   alu_a_source,
  input  logic                   alu_b_source,
  input  logic [WIDTH-1:0]       alu_a_altern,
  input  logic [WIDTH-1:0]       alu_b_altern,
  input  logic [SELW-1:0]        alu_out_select,
  input  logic [1:0]             alu_load_src,
  output logic                   busy,
  output logic                   done,
  output logic [WIDTH-1:0]       alu_output,
  output logic [4:0]             flags,
  output logic [NREGS*WIDTH-1:0] registers
);

  localparam logic [3:0] OP_PASS = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SHL  = 4'd6;
  localparam logic [3:0] OP_SHR  = 4'd7;
  localparam logic [3:0] OP_SRA  = 4'd8;
  localparam logic [3:0] OP_MUL  = 4'd9;

  localparam logic [1:0] LD_ALU = 2'b01;
  localparam logic [1:0] LD_B   = 2'b10;

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   regs_q [NREGS];
  logic [WIDTH-1:0]   alu_output_q;
  logic [4:0]         flags_q;
  logic               done_q;

  // Multiplier operands are captured at accept so input changes cannot disturb it.
  logic [2*WIDTH-1:0] mul_acc_q;
  logic [2*WIDTH-1:0] mul_a_q;
  logic [WIDTH-1:0]   mul_b_q;
  logic [WIDTH-1:0]   mul_bop_q;
  logic [SELW-1:0]    mul_dst_q;
  logic [1:0]         mul_ld_q;
  logic [SHW-1:0]     mul_cnt_q;

  logic [2*WIDTH-1:0] mul_acc_d;
  logic [WIDTH-1:0]   mul_res;
  logic               mul_hi;
  logic               mul_last;

  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic [SHW-1:0]     shamt;
  logic [WIDTH:0]     sum_ext;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c;
  logic               alu_v;
  logic               alu_err;

  assign op_a  = alu_a_source ? alu_a_altern : regs_q[alu_a_select];
  assign op_b  = alu_b_source ? alu_b_altern : regs_q[alu_b_select];
  assign shamt = op_b[SHW-1:0];

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_err = 1'b0;
    sum_ext = '0;
    case (alu_op)
      OP_PASS: alu_res = op_a;
      OP_ADD: begin
        sum_ext = {1'b0, op_a} + {1'b0, op_b};
        alu_res = sum_ext[WIDTH-1:0];
        alu_c   = sum_ext[WIDTH];
        alu_v   = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (alu_res[WIDTH-1] != op_a[WIDTH-1]);
      end
      OP_SUB: begin
        // The extra top bit of the widened difference is the borrow.
        sum_ext = {1'b0, op_a} - {1'b0, op_b};
        alu_res = sum_ext[WIDTH-1:0];
        alu_c   = sum_ext[WIDTH];
        alu_v   = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (alu_res[WIDTH-1] != op_a[WIDTH-1]);
      end
      OP_AND:  alu_res = op_a & op_b;
      OP_OR:   alu_res = op_a | op_b;
      OP_XOR:  alu_res = op_a ^ op_b;
      OP_SHL:  alu_res = op_a << shamt;
      OP_SHR:  alu_res = op_a >> shamt;
      OP_SRA:  alu_res = $signed(op_a) >>> shamt;
      OP_MUL:  alu_res = '0;
      default: alu_err = 1'b1;
    endcase
  end

  assign mul_acc_d = mul_acc_q + (mul_b_q[0] ? mul_a_q : '0);
  assign mul_res   = mul_acc_d[WIDTH-1:0];
  assign mul_hi    = |mul_acc_d[2*WIDTH-1:WIDTH];
  assign mul_last  = (mul_cnt_q == SHW'(WIDTH - 1));

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int r = 0; r < NREGS; r++) regs_q[r] <= '0;
      state_q      <= S_IDLE;
      alu_output_q <= '0;
      flags_q      <= '0;
      done_q       <= 1'b0;
      mul_acc_q    <= '0;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      mul_bop_q    <= '0;
      mul_dst_q    <= '0;
      mul_ld_q     <= '0;
      mul_cnt_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (program_counter_increment)
            regs_q[PC_REG] <= regs_q[PC_REG] + WIDTH'(1);
          if (issue) begin
            if (alu_op == OP_MUL) begin
              state_q   <= S_MUL;
              mul_acc_q <= '0;
              mul_a_q   <= {{WIDTH{1'b0}}, op_a};
              mul_b_q   <= op_b;
              mul_bop_q <= op_b;
              mul_dst_q <= alu_out_select;
              mul_ld_q  <= alu_load_src;
              mul_cnt_q <= '0;
            end else begin
              alu_output_q <= alu_res;
              flags_q      <= {alu_err, alu_c, alu_v, alu_res == '0, alu_res[WIDTH-1]};
              done_q       <= 1'b1;
              // Placed after the PC increment so a write-back to PC_REG wins.
              if (!alu_err) begin
                if (alu_load_src == LD_ALU) regs_q[alu_out_select] <= alu_res;
                else if (alu_load_src == LD_B) regs_q[alu_out_select] <= op_b;
              end
            end
          end
        end
        S_MUL: begin
          mul_acc_q <= mul_acc_d;
          mul_a_q   <= mul_a_q << 1;
          mul_b_q   <= mul_b_q >> 1;
          mul_cnt_q <= mul_cnt_q + SHW'(1);
          if (mul_last) begin
            state_q      <= S_IDLE;
            alu_output_q <= mul_res;
            flags_q      <= {1'b0, mul_hi, mul_hi, mul_res == '0, mul_res[WIDTH-1]};
            done_q       <= 1'b1;
            if (mul_ld_q == LD_ALU) regs_q[mul_dst_q] <= mul_res;
            else if (mul_ld_q == LD_B) regs_q[mul_dst_q] <= mul_bop_q;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy       = (state_q == S_MUL);
  assign done       = done_q;
  assign alu_output = alu_output_q;
  assign flags      = flags_q;

  for (genvar gi = 0; gi < NREGS; gi++) begin : g_flat
    assign registers[gi*WIDTH +: WIDTH] = regs_q[gi];
  end

endmodule

// File: tb/tb_param_datapath.sv
// Bench for param_datapath: 16x16 instance against an arithmetic reference model,
// plus an 8x8 instance for the narrow-width corner cases.
module tb_param_datapath;

  logic         clock = 1'b0;
  logic         resetn = 1'b0;
  logic         pci, issue, a_src, b_src, busy, done;
  logic [3:0]   op, a_sel, b_sel, out_sel;
  logic [15:0]  a_alt, b_alt, alu_out;
  logic [1:0]   ld;
  logic [4:0]   flags;
  logic [255:0] regs;

  logic         pci8, issue8, a_src8, b_src8, busy8, done8;
  logic [3:0]   op8;
  logic [2:0]   a_sel8, b_sel8, out_sel8;
  logic [7:0]   a_alt8, b_alt8, alu_out8;
  logic [1:0]   ld8;
  logic [4:0]   flags8;
  logic [63:0]  regs8;

  int n_pass = 0;
  int n_total = 0;

  always #5 clock = ~clock;

  param_datapath #(.WIDTH(16), .NREGS(16), .PC_REG(0)) dut (
    .clock(clock), .resetn(resetn), .program_counter_increment(pci), .issue(issue),
    .alu_op(op), .alu_a_select(a_sel), .alu_b_select(b_sel),
    .alu_a_source(a_src), .alu_b_source(b_src), .alu_a_altern(a_alt), .alu_b_altern(b_alt),
    .alu_out_select(out_sel), .alu_load_src(ld), .busy(busy), .done(done),
    .alu_output(alu_out), .flags(flags), .registers(regs)
  );

  param_datapath #(.WIDTH(8), .NREGS(8), .PC_REG(0)) dut8 (
    .clock(clock), .resetn(resetn), .program_counter_increment(pci8), .issue(issue8),
    .alu_op(op8), .alu_a_select(a_sel8), .alu_b_select(b_sel8),
    .alu_a_source(a_src8), .alu_b_source(b_src8), .alu_a_altern(a_alt8), .alu_b_altern(b_alt8),
    .alu_out_select(out_sel8), .alu_load_src(ld8), .busy(busy8), .done(done8),
    .alu_output(alu_out8), .flags(flags8), .registers(regs8)
  );

  // Reference model state (16-bit instance)
  logic [15:0] m_regs [16];
  logic [15:0] m_out, p_res, p_b;
  logic [4:0]  m_flags, p_fl;
  logic [3:0]  p_dst;
  logic [1:0]  p_ld;
  bit          m_busy, m_done;
  int          m_left;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [15:0] r16(input int i);
    return regs[i*16 +: 16];
  endfunction

  function automatic logic [7:0] r8(input int i);
    return regs8[i*8 +: 8];
  endfunction

  // Flags {error, carry, overflow, zero, sign} from plain integer arithmetic.
  function automatic void alu_ref(input int w, input int o, input longint a, input longint b,
                                  output longint res, output logic [4:0] fl);
    longint mask, full, sa, sb, s, lo, hi;
    int sh;
    logic c, v, e;
    mask = (longint'(1) << w) - 1;
    hi   = (longint'(1) << (w - 1)) - 1;
    lo   = -(longint'(1) << (w - 1));
    sa   = (a > hi) ? a - (mask + 1) : a;
    sb   = (b > hi) ? b - (mask + 1) : b;
    sh   = int'(b & longint'(w - 1));
    c = 1'b0; v = 1'b0; e = 1'b0; res = 0;
    case (o)
      0: res = a;
      1: begin full = a + b; res = full & mask; c = full > mask; s = sa + sb; v = (s > hi) || (s < lo); end
      2: begin full = a - b; res = full & mask; c = a < b;       s = sa - sb; v = (s > hi) || (s < lo); end
      3: res = a & b;
      4: res = a | b;
      5: res = a ^ b;
      6: res = (a << sh) & mask;
      7: res = a >> sh;
      8: res = (sa >>> sh) & mask;
      9: begin full = a * b; res = full & mask; c = (full >> w) != 0; v = c; end
      default: e = 1'b1;
    endcase
    fl = {e, c, v, res == 0, ((res >> (w - 1)) & 1) != 0};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = '0;
    m_out = '0; m_flags = '0; m_busy = 0; m_done = 0; m_left = 0;
  endtask

  task automatic model_edge();
    logic [15:0] nr [16];
    longint a, b, res;
    logic [4:0] fl;
    nr = m_regs;
    m_done = 0;
    if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
        m_busy = 0; m_done = 1; m_out = p_res; m_flags = p_fl;
        if (p_ld == 2'b01) nr[p_dst] = p_res;
        else if (p_ld == 2'b10) nr[p_dst] = p_b;
      end
    end else begin
      if (pci) nr[0] = m_regs[0] + 16'd1;
      if (issue) begin
        a = longint'(a_src ? a_alt : m_regs[a_sel]);
        b = longint'(b_src ? b_alt : m_regs[b_sel]);
        alu_ref(16, int'(op), a, b, res, fl);
        if (op == 4'd9) begin
          m_busy = 1; m_left = 16; p_res = res[15:0]; p_fl = fl; p_b = b[15:0];
          p_dst = out_sel; p_ld = ld;
        end else begin
          m_done = 1; m_out = res[15:0]; m_flags = fl;
          if (!fl[4]) begin
            if (ld == 2'b01) nr[out_sel] = res[15:0];
            else if (ld == 2'b10) nr[out_sel] = b[15:0];
          end
        end
      end
    end
    m_regs = nr;
  endtask

  task automatic model_cmp();
    logic [255:0] packed_regs;
    for (int i = 0; i < 16; i++) packed_regs[i*16 +: 16] = m_regs[i];
    chk("model_busy", busy, m_busy);
    chk("model_done", done, m_done);
    chk("model_alu_output", alu_out, m_out);
    chk("model_flags", flags, m_flags);
    chk("model_registers", regs, packed_regs);
  endtask

  // Inputs are driven at the falling edge; outputs compared at the next falling edge.
  task automatic tick();
    model_edge();
    @(posedge clock);
    @(negedge clock);
    model_cmp();
  endtask

  task automatic drv(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b,
                     input logic [3:0] dst, input logic [1:0] l, input logic p);
    issue = 1'b1; op = o; a_src = 1'b1; b_src = 1'b1; a_alt = a; b_alt = b;
    out_sel = dst; ld = l; pci = p;
  endtask

  task automatic idle();
    issue = 1'b0; pci = 1'b0;
  endtask

  task automatic drv8(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b,
                      input logic [2:0] dst, input logic [1:0] l);
    issue8 = 1'b1; op8 = o; a_src8 = 1'b1; b_src8 = 1'b1; a_alt8 = a; b_alt8 = b;
    out_sel8 = dst; ld8 = l;
  endtask

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 5))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h7FFF;
      3: return 16'h8000;
      4: return 16'($urandom_range(0, 31));
      default: return 16'($urandom);
    endcase
  endfunction

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic [4:0]  fl;
    logic [15:0] reg5;
  } vec_t;

  vec_t vecs [12];

  initial begin
    logic [255:0] snap;
    logic [15:0]  snap_pc;

    vecs[0]  = '{4'h1, 16'h7FFF, 16'h0001, 16'h8000, 5'b00101, 16'h8000};
    vecs[1]  = '{4'h2, 16'h0000, 16'h0001, 16'hFFFF, 5'b01001, 16'hFFFF};
    vecs[2]  = '{4'h1, 16'hFFFF, 16'h0001, 16'h0000, 5'b01010, 16'h0000};
    vecs[3]  = '{4'h2, 16'h8000, 16'h0001, 16'h7FFF, 5'b00100, 16'h7FFF};
    vecs[4]  = '{4'h3, 16'hF0F0, 16'h0FF0, 16'h00F0, 5'b00000, 16'h00F0};
    vecs[5]  = '{4'h4, 16'hF000, 16'h000F, 16'hF00F, 5'b00001, 16'hF00F};
    vecs[6]  = '{4'h5, 16'hAAAA, 16'hAAAA, 16'h0000, 5'b00010, 16'h0000};
    vecs[7]  = '{4'h6, 16'h0001, 16'h0013, 16'h0008, 5'b00000, 16'h0008};
    vecs[8]  = '{4'h7, 16'h8000, 16'h0004, 16'h0800, 5'b00000, 16'h0800};
    vecs[9]  = '{4'h8, 16'h8000, 16'h0004, 16'hF800, 5'b00001, 16'hF800};
    vecs[10] = '{4'h0, 16'h1234, 16'h5555, 16'h1234, 5'b00000, 16'h1234};
    vecs[11] = '{4'hE, 16'h1111, 16'h2222, 16'h0000, 5'b10010, 16'h1234};

    pci = 0; issue = 0; op = 0; a_sel = 0; b_sel = 0; a_src = 0; b_src = 0;
    a_alt = 0; b_alt = 0; out_sel = 0; ld = 0;
    pci8 = 0; issue8 = 0; op8 = 0; a_sel8 = 0; b_sel8 = 0; a_src8 = 0; b_src8 = 0;
    a_alt8 = 0; b_alt8 = 0; out_sel8 = 0; ld8 = 0;
    model_reset();

    // Reset state
    #12;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_alu_output", alu_out, 0);
    chk("reset_flags", flags, 0);
    chk("reset_registers", regs, 0);
    @(negedge clock);
    resetn = 1'b1;

    // reg7 + 2 -> reg7 with a simultaneous PC increment
    drv(4'h1, 16'h0, 16'h0002, 4'd7, 2'b01, 1'b1);
    a_src = 1'b0; a_sel = 4'd7;
    tick();
    idle();
    chk("tp1_reg7", r16(7), 16'h0002);
    chk("tp1_pc", r16(0), 16'h0001);
    chk("tp1_done", done, 1);
    chk("tp1_zero", flags[1], 0);
    tick();
    chk("tp1_done_pulse_ends", done, 0);

    // Single-cycle vector table, destination reg5
    for (int i = 0; i < 12; i++) begin
      drv(vecs[i].op, vecs[i].a, vecs[i].b, 4'd5, 2'b01, 1'b0);
      tick();
      chk($sformatf("vec%0d_result", i), alu_out, vecs[i].res);
      chk($sformatf("vec%0d_flags", i), flags, vecs[i].fl);
      chk($sformatf("vec%0d_done", i), done, 1);
      chk($sformatf("vec%0d_reg5", i), r16(5), vecs[i].reg5);
    end
    idle();

    // Operand-B load, then MUL 0x100*0x100 with issue/PC increment held during busy
    drv(4'h0, 16'h0, 16'h0055, 4'd3, 2'b10, 1'b0);
    tick();
    chk("loadb_reg3", r16(3), 16'h0055);
    drv(4'h9, 16'h0100, 16'h0100, 4'd3, 2'b01, 1'b0);
    tick();
    chk("mul_busy_e0", busy, 1);
    chk("mul_no_done_e0", done, 0);
    snap = regs;
    snap_pc = r16(0);
    drv(4'h1, 16'h0001, 16'h0001, 4'd3, 2'b01, 1'b1);
    for (int k = 1; k < 16; k++) begin
      tick();
      chk($sformatf("mul_busy_%0d", k), busy, 1);
      chk($sformatf("mul_regs_frozen_%0d", k), regs, snap);
    end
    tick();
    chk("mul_busy_fall", busy, 0);
    chk("mul_done", done, 1);
    chk("mul_result", alu_out, 16'h0000);
    chk("mul_flags", flags, 5'b01110);
    chk("mul_reg3", r16(3), 16'h0000);
    chk("mul_pc_ignored", r16(0), snap_pc);
    tick();
    chk("post_mul_accept_reg3", r16(3), 16'h0002);
    chk("post_mul_accept_pc", r16(0), snap_pc + 16'd1);
    chk("post_mul_accept_done", done, 1);
    idle();

    // Asynchronous reset in the middle of a MUL
    drv(4'h9, 16'h0003, 16'h0005, 4'd4, 2'b01, 1'b0);
    tick();
    idle();
    repeat (5) tick();
    chk("pre_reset_busy", busy, 1);
    resetn = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_alu_output", alu_out, 0);
    chk("midrst_flags", flags, 0);
    chk("midrst_registers", regs, 0);
    model_reset();
    @(negedge clock);
    resetn = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk($sformatf("midrst_no_done_%0d", k), done, 0);
    end
    chk("midrst_reg4_unwritten", r16(4), 16'h0000);

    // Write-back to PC beats the increment; PC wraps from all-ones
    drv(4'h0, 16'h0040, 16'h0, 4'd0, 2'b01, 1'b1);
    tick();
    chk("pc_wb_wins", r16(0), 16'h0040);
    drv(4'h0, 16'hFFFF, 16'h0, 4'd0, 2'b01, 1'b0);
    tick();
    idle();
    pci = 1'b1;
    tick();
    chk("pc_wrap", r16(0), 16'h0000);
    idle();

    // Narrow instance: shift uses low bits of B, illegal op, MUL latency of 8
    drv8(4'h6, 8'h01, 8'h0B, 3'd2, 2'b01);
    tick();
    chk("w8_shl_result", alu_out8, 8'h08);
    chk("w8_shl_reg2", r8(2), 8'h08);
    chk("w8_shl_done", done8, 1);
    drv8(4'hC, 8'h55, 8'h33, 3'd2, 2'b01);
    tick();
    chk("w8_illegal_result", alu_out8, 8'h00);
    chk("w8_illegal_flags", flags8, 5'b10010);
    chk("w8_illegal_no_write", r8(2), 8'h08);
    chk("w8_illegal_done", done8, 1);
    drv8(4'h9, 8'h0F, 8'h0F, 3'd1, 2'b01);
    tick();
    issue8 = 1'b0;
    for (int k = 1; k < 8; k++) begin
      tick();
      chk($sformatf("w8_mul_busy_%0d", k), busy8, 1);
    end
    tick();
    chk("w8_mul_busy_fall", busy8, 0);
    chk("w8_mul_done", done8, 1);
    chk("w8_mul_result", alu_out8, 8'hE1);
    chk("w8_mul_flags", flags8, 5'b00001);
    chk("w8_mul_reg1", r8(1), 8'hE1);

    // Randomized traffic against the reference model
    for (int k = 0; k < 400; k++) begin
      issue   = ($urandom_range(0, 3) != 0);
      op      = 4'($urandom_range(0, 15));
      a_sel   = 4'($urandom);
      b_sel   = 4'($urandom);
      a_src   = 1'($urandom);
      b_src   = 1'($urandom);
      a_alt   = pick();
      b_alt   = pick();
      out_sel = 4'($urandom);
      ld      = 2'($urandom);
      pci     = ($urandom_range(0, 3) == 0);
      tick();
    end
    idle();
    repeat (20) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/param_datapath.md
# param_datapath

Parametrised successor to the 16×16 datapath: a register file of NREGS registers of WIDTH bits, with one register reserved as program counter, a two-operand ALU and a flags register. Adds a multi-cycle unsigned multiply with an issue/busy/done handshake, so the control FSM can sequence variable-latency operations. It sits between the instruction-decode controller and the register/VGA consumers, which read the flattened `registers` bus.

## Interface
- WIDTH, 16: register and ALU width; minimum 4.
- NREGS, 16: number of registers; power of two, at least 2.
- PC_REG, 0: index of the program-counter register.
- SELW, clog2(NREGS): width of the select ports (derived).
- SHW, clog2(WIDTH): width of the shift amount (derived).

Ports:
- clock  in  1  rising-edge clock.
- resetn  in  1  asynchronous, active-low reset.
- program_counter_increment  in  1  increment PC_REG at this edge.
- issue  in  1  command valid; accepted at an edge where issue=1 and busy=0.
- alu_op  in  4  operation code (see Operation).
- alu_a_select, alu_b_select  in  SELW  operand register indices.
- alu_a_source, alu_b_source  in  1  0 = register, 1 = altern input.
- alu_a_altern, alu_b_altern  in  WIDTH  immediate operands.
- alu_out_select  in  SELW  destination register.
- alu_load_src  in  2  00 no write, 01 ALU result, 10 operand B, 11 no write.
- busy  out  1  multi-cycle operation in flight.
- done  out  1  one-cycle pulse: result and flags valid.
- alu_output  out  WIDTH  registered result of the last completed op.
- flags  out  5  {error, carry, overflow, zero, sign}.
- registers  out  NREGS*WIDTH  register r at bits [r*WIDTH +: WIDTH].

## Operation
- Ops: 0 pass A; 1 A+B; 2 A−B; 3 AND; 4 OR; 5 XOR; 6 A<<B[SHW-1:0]; 7 logical right shift; 8 arithmetic right shift; 9 MUL, which is the unsigned low WIDTH bits of the product; A–F illegal.
- Shifts use only B[SHW-1:0]; the upper bits of B are ignored.
- Operands are latched at the accept edge; later changes to the inputs do not affect an op in flight.
- Flags update on every completed op, regardless of alu_load_src.
  - zero and sign are taken from the WIDTH-bit result.
  - add: carry = unsigned carry-out; overflow = signed overflow.
  - sub: carry = borrow (A<B unsigned); overflow = signed overflow.
  - MUL: carry = overflow = 1 when the high half of the full product is nonzero.
  - logic ops and shifts: carry = overflow = 0.
  - error = 1 only for an illegal op. An illegal op has result 0, writes nothing and still pulses done.
- Write-back goes to alu_out_select. If the destination is PC_REG, the write-back wins over the increment at the same edge.
- MUL FSM has two states.
  - IDLE→MUL on an accepted op 9.
  - MUL is a shift-add loop counting WIDTH edges, then returns to IDLE with write-back.
- An issue while busy=1 is ignored with no side effects.
- program_counter_increment is ignored while busy=1. Otherwise PC_REG increments by 1, wrapping to 0 from all-ones.

## Timing
- Reset (asynchronous): all registers 0, alu_output 0, flags 0, busy 0, done 0, FSM IDLE.
  - Reset during MUL aborts the op with no write-back and no done pulse.
- Single-cycle op accepted at edge E0:
  - write-back, alu_output and flags update at E0.
  - done = 1 for the cycle after E0; busy stays 0.
  - Back-to-back issue every cycle is legal.
- MUL accepted at edge E0:
  - busy = 1 from E0 until edge E0+WIDTH.
  - write-back, alu_output and flags update at E0+WIDTH; busy falls and done = 1 for the following cycle.
  - A new issue is accepted at E0+WIDTH+1 at the earliest.
- Register reads are combinational from current state. Reading a register that is written at the same edge returns the old value.
- The `registers` bus reflects state after each edge, with no extra latency.

## Test plan
- Reset, then WIDTH=16, issue op1 with A=reg7 (0), B=altern 2, out=7, load 01, PC increment -> after one edge reg7=2, reg0=1, done pulse, flags zero=0.
- op1 with 0x7FFF+1 -> result 0x8000, overflow=1, sign=1, carry=0; then op2 with 0−1 -> result 0xFFFF, carry=1.
- MUL 0x0100×0x0100 -> busy for 16 cycles, result 0, carry=overflow=1, zero=1.
  - An issue and a PC increment asserted while busy leave all registers unchanged.
- Assert resetn low mid-MUL -> all outputs 0 immediately; the destination register is not written; no done pulse.
- Same edge: PC increment with write-back out=PC_REG value 0x40 -> reg0=0x40. PC at 0xFFFF with increment -> 0x0000.
- NREGS=8, WIDTH=8: op6 with B=0x0B shifts by 3 (0x01→0x08). op 0xC -> error=1, result 0, no write.
